// File: rtl/transceiver_ctrl.sv
// ---------------------------------------------------------------------------
// transceiver_ctrl
//
// Frame sequencer for a UART -> Hamming encoder -> modulator -> demodulator
// -> Hamming decoder -> UART loop. Received bytes are buffered in a small
// FIFO. Each byte is encoded, modulated for DATA_WIDTH symbols of
// SAMPLE_NUMBER carrier samples each, decoded and handed to the transmitter.
//
// Parameters
//   SAMPLE_NUMBER  carrier samples per symbol (power of two)
//   DATA_WIDTH     Hamming codeword bits = symbols per frame
//   FIFO_DEPTH     received-byte buffer depth (power of two, >= 2)
//   TIMEOUT_CYCLES WAIT-state watchdog limit (only used with the macro)
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   rx_dv        strobe: rx_byte valid
//   rx_byte      byte from the UART receiver
//   sample_cnt   sample index of the sine generator
//   dec_byte     Hamming decoder output
//   tx_done      strobe: UART transmitter finished a byte
//   enc_wren     encoder load strobe (one cycle, LOAD)
//   enc_byte     byte presented to the encoder
//   gen_en       sine generator / modulator / demodulator enable (MOD)
//   dec_rden     decoder read strobe (one cycle, DEC)
//   tx_dv        transmitter start strobe (one cycle, SEND)
//   tx_byte      byte presented to the transmitter
//   busy         high whenever the sequencer is not IDLE
//   overflow     one-cycle pulse: a received byte was dropped
//   timeout_err  one-cycle pulse: WAIT watchdog expired
//
// Build option
//   TRANSCEIVER_CTRL_TIMEOUT_EN  enables the WAIT-state watchdog. Without
//   it WAIT holds until tx_done and timeout_err is tied low.
// ---------------------------------------------------------------------------
module transceiver_ctrl #(
  parameter int SAMPLE_NUMBER  = 256,
  parameter int DATA_WIDTH     = 12,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx_dv,
  input  logic [7:0]                       rx_byte,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0] sample_cnt,
  input  logic [7:0]                       dec_byte,
  input  logic                             tx_done,
  output logic                             enc_wren,
  output logic [7:0]                       enc_byte,
  output logic                             gen_en,
  output logic                             dec_rden,
  output logic                             tx_dv,
  output logic [7:0]                       tx_byte,
  output logic                             busy,
  output logic                             overflow,
  output logic                             timeout_err
);

  localparam int SC_W  = $clog2(SAMPLE_NUMBER);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int SYM_W = $clog2(DATA_WIDTH + 1);

  localparam logic [SC_W-1:0]  LAST_SAMPLE = SC_W'(SAMPLE_NUMBER - 1);
  localparam logic [SYM_W-1:0] LAST_SYMBOL = SYM_W'(DATA_WIDTH - 1);

  // Reject configurations the pointer and boundary arithmetic cannot handle.
  if ((SAMPLE_NUMBER < 32'd2) || ((SAMPLE_NUMBER & (SAMPLE_NUMBER - 32'd1)) != 32'd0) ||
      (FIFO_DEPTH < 32'd2) || ((FIFO_DEPTH & (FIFO_DEPTH - 32'd1)) != 32'd0) ||
      (DATA_WIDTH < 32'd1) || (TIMEOUT_CYCLES < 32'd1)) begin : g_bad_params
    $error("transceiver_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MOD  = 3'd2,
    ST_DEC  = 3'd3,
    ST_SEND = 3'd4,
    ST_WAIT = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [SYM_W-1:0]     sym_cnt_q, sym_cnt_d;
  logic [7:0]           enc_byte_q, enc_byte_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 enc_wren_q, enc_wren_d;
  logic                 gen_en_q, gen_en_d;
  logic                 dec_rden_q, dec_rden_d;
  logic                 tx_dv_q, tx_dv_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;

  // FIFO: the extra pointer MSB separates full from empty when indices match.
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [7:0]           mem_d [FIFO_DEPTH];
  logic                 fifo_empty_s;
  logic                 fifo_full_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 boundary_s;

`ifdef TRANSCEIVER_CTRL_TIMEOUT_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] LAST_WD = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic                 timeout_err_q, timeout_err_d;
`endif

  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  // The last sample of a symbol only counts while the generator is running.
  assign boundary_s   = gen_en_q && (sample_cnt == LAST_SAMPLE);

  // Sequencer next-state, symbol counter, watchdog and captured bytes.
  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q;
    enc_byte_d = enc_byte_q;
    tx_byte_d  = tx_byte_q;
    pop_s      = 1'b0;
`ifdef TRANSCEIVER_CTRL_TIMEOUT_EN
    wd_cnt_d      = {WD_W{1'b0}};
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          enc_byte_d = mem_q[rd_ptr_q[PTR_W-1:0]];
          state_d    = ST_LOAD;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_LOAD: begin
        sym_cnt_d = {SYM_W{1'b0}};
        state_d   = ST_MOD;
      end
      ST_MOD: begin
        if (boundary_s) begin
          if (sym_cnt_q == LAST_SYMBOL) begin
            sym_cnt_d = {SYM_W{1'b0}};
            state_d   = ST_DEC;
          end else begin
            sym_cnt_d = sym_cnt_q + SYM_W'(1);
          end
        end else begin
          sym_cnt_d = sym_cnt_q;
        end
      end
      ST_DEC: begin
        // Decoder output is valid while dec_rden is high.
        tx_byte_d = dec_byte;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end
`ifdef TRANSCEIVER_CTRL_TIMEOUT_EN
        else if (wd_cnt_q == LAST_WD) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`else
        else begin
          state_d = ST_WAIT;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointers/storage and the registered strobes derived from next state.
  always_comb begin
    mem_d      = mem_q;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push_s     = rx_dv && (!fifo_full_s || pop_s);
    overflow_d = rx_dv && fifo_full_s && !pop_s;
    if (push_s) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = rx_byte;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    enc_wren_d = (state_d == ST_LOAD);
    gen_en_d   = (state_d == ST_MOD);
    dec_rden_d = (state_d == ST_DEC);
    tx_dv_d    = (state_d == ST_SEND);
    busy_d     = (state_d != ST_IDLE);
  end

  // Control and output registers; reset also drops any rx_dv in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sym_cnt_q  <= {SYM_W{1'b0}};
      enc_byte_q <= 8'h00;
      tx_byte_q  <= 8'h00;
      enc_wren_q <= 1'b0;
      gen_en_q   <= 1'b0;
      dec_rden_q <= 1'b0;
      tx_dv_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= {(PTR_W+1){1'b0}};
      rd_ptr_q   <= {(PTR_W+1){1'b0}};
`ifdef TRANSCEIVER_CTRL_TIMEOUT_EN
      wd_cnt_q      <= {WD_W{1'b0}};
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      enc_byte_q <= enc_byte_d;
      tx_byte_q  <= tx_byte_d;
      enc_wren_q <= enc_wren_d;
      gen_en_q   <= gen_en_d;
      dec_rden_q <= dec_rden_d;
      tx_dv_q    <= tx_dv_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef TRANSCEIVER_CTRL_TIMEOUT_EN
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  // FIFO data storage; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign enc_wren = enc_wren_q;
  assign enc_byte = enc_byte_q;
  assign gen_en   = gen_en_q;
  assign dec_rden = dec_rden_q;
  assign tx_dv    = tx_dv_q;
  assign tx_byte  = tx_byte_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
`ifdef TRANSCEIVER_CTRL_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_transceiver_ctrl.sv
// ---------------------------------------------------------------------------
// tb_transceiver_ctrl
//
// Directed bench for transceiver_ctrl with SAMPLE_NUMBER=4, DATA_WIDTH=12,
// FIFO_DEPTH=4, TIMEOUT_CYCLES=16. A frame therefore spends 48 cycles in MOD.
// The sine generator is stood in for by a 2-bit counter that runs while
// gen_en is high. Inputs are driven and outputs sampled 1 time unit after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_transceiver_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic [1:0] sample_cnt = 2'd0;
  logic [7:0] dec_byte;
  logic       tx_done;
  logic       enc_wren;
  logic [7:0] enc_byte;
  logic       gen_en;
  logic       dec_rden;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       busy;
  logic       overflow;
  logic       timeout_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] push_q [$];

  transceiver_ctrl #(
    .SAMPLE_NUMBER (4),
    .DATA_WIDTH    (12),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_dv      (rx_dv),
    .rx_byte    (rx_byte),
    .sample_cnt (sample_cnt),
    .dec_byte   (dec_byte),
    .tx_done    (tx_done),
    .enc_wren   (enc_wren),
    .enc_byte   (enc_byte),
    .gen_en     (gen_en),
    .dec_rden   (dec_rden),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .busy       (busy),
    .overflow   (overflow),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Sine generator stand-in: sample index advances only while enabled.
  always_ff @(posedge clk) begin
    if (gen_en === 1'b1) sample_cnt <= sample_cnt + 2'd1;
    else                 sample_cnt <= 2'd0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until the LOAD strobe appears, then check the encoder handoff.
  task automatic wait_load(input logic [7:0] exp);
    int n = 0;
    while (enc_wren !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("load_strobe", enc_wren, 1);
    chk("enc_byte", enc_byte, exp);
    chk("load_gen_off", gen_en, 0);
    chk("load_busy", busy, 1);
  endtask

  // From the LOAD sample: run MOD (pushing queued bytes, one stray tx_done),
  // then check DEC, SEND and the first WAIT cycle.
  task automatic mod_to_wait(input logic [7:0] dec_val, input int exp_ovf_at);
    int gen_n = 0;
    int bnd   = 0;
    int lat   = 0;
    int pushed = 0;
    int ovf_n = 0;
    int ovf_at = 0;
    dec_byte = dec_val;
    while (dec_rden !== 1'b1 && lat < 400) begin
      if (gen_en === 1'b1 && push_q.size() > 0) begin
        rx_dv   = 1'b1;
        rx_byte = push_q.pop_front();
        pushed++;
      end else begin
        rx_dv = 1'b0;
      end
      tx_done = (gen_n == 10) ? 1'b1 : 1'b0;
      step();
      lat++;
      rx_dv   = 1'b0;
      tx_done = 1'b0;
      if (overflow === 1'b1) begin
        ovf_n++;
        ovf_at = pushed;
      end
      if (gen_en === 1'b1) begin
        gen_n++;
        if (sample_cnt == 2'd3) bnd++;
      end
    end
    push_q.delete();
    chk("dec_strobe", dec_rden, 1);
    chk("dec_gen_off", gen_en, 0);
    chk("mod_cycles", gen_n, 48);
    chk("mod_boundaries", bnd, 12);
    chk("load_to_dec_latency", lat, 49);
    chk("overflow_pulses", ovf_n, (exp_ovf_at != 0) ? 1 : 0);
    chk("overflow_at_push", ovf_at, exp_ovf_at);
    step();
    chk("send_tx_dv", tx_dv, 1);
    chk("send_tx_byte", tx_byte, dec_val);
    chk("send_dec_off", dec_rden, 0);
    step();
    chk("wait_tx_dv_off", tx_dv, 0);
    chk("wait_busy", busy, 1);
  endtask

  task automatic finish_frame();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("done_busy_off", busy, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    step();
    rx_dv   = 1'b0;
  endtask

  initial begin
    int   n;
    int   bnd;
    logic bad;
    rst      = 1'b1;
    rx_dv    = 1'b0;
    rx_byte  = 8'h00;
    tx_done  = 1'b0;
    dec_byte = 8'h00;
    step();
    step();
    chk("reset_outputs",
        {enc_wren, enc_byte, gen_en, dec_rden, tx_dv, tx_byte, busy, overflow, timeout_err},
        32'd0);
    rst = 1'b0;

    // Stray tx_done in IDLE
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("stray_done_idle_busy", busy, 0);
    chk("stray_done_idle_load", enc_wren, 0);

    // Single byte 0xA5, decoder returns 0x3C
    send_byte(8'hA5);
    chk("push_cycle_still_idle", busy, 0);
    wait_load(8'hA5);
    mod_to_wait(8'h3C, 0);

`ifdef TRANSCEIVER_CTRL_TIMEOUT_EN
    bad = 1'b0;
    repeat (15) begin
      step();
      if (timeout_err !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    chk("watchdog_early", bad, 0);
    step();
    chk("watchdog_pulse", timeout_err, 1);
    chk("watchdog_idle", busy, 0);
    step();
    chk("watchdog_pulse_end", timeout_err, 0);
`else
    bad = 1'b0;
    repeat (40) begin
      step();
      if (timeout_err !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    chk("wait_holds", bad, 0);
    finish_frame();
`endif

    // Back-to-back: five strobes during MOD, fifth one is dropped
    send_byte(8'h11);
    wait_load(8'h11);
    push_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    mod_to_wait(8'hE1, 5);
    finish_frame();
    for (int i = 1; i <= 4; i++) begin
      logic [7:0] b;
      b = 8'h20 + 8'(i);
      wait_load(b);
      mod_to_wait(~b, 0);
      finish_frame();
    end
    step();
    step();
    chk("dropped_byte_not_sent", {busy, enc_wren}, 0);

    // Full FIFO with rx_dv in the same cycle as the IDLE pop
    send_byte(8'h40);
    wait_load(8'h40);
    push_q = '{8'h31, 8'h32, 8'h33, 8'h34};
    mod_to_wait(8'hBF, 0);
    finish_frame();
    send_byte(8'h35);
    chk("simul_no_overflow", overflow, 0);
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] b;
      b = 8'h30 + 8'(i);
      wait_load(b);
      mod_to_wait(b ^ 8'h5A, 0);
      finish_frame();
    end

    // Reset in MOD after five boundaries; rx_dv during reset is ignored
    send_byte(8'h55);
    wait_load(8'h55);
    bnd = 0;
    n   = 0;
    while (bnd < 5 && n < 100) begin
      step();
      n++;
      if (gen_en === 1'b1 && sample_cnt == 2'd3) bnd++;
    end
    chk("reset_point_in_mod", gen_en, 1);
    rst     = 1'b1;
    rx_dv   = 1'b1;
    rx_byte = 8'h66;
    step();
    rst   = 1'b0;
    rx_dv = 1'b0;
    chk("mid_reset_outputs",
        {enc_wren, enc_byte, gen_en, dec_rden, tx_dv, tx_byte, busy, overflow, timeout_err},
        32'd0);
    bad = 1'b0;
    repeat (80) begin
      step();
      if (tx_dv !== 1'b0 || busy !== 1'b0 || enc_wren !== 1'b0) bad = 1'b1;
    end
    chk("after_reset_fifo_empty", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/transceiver_ctrl.md
TRANSCEIVER_CTRL -- requirements
Module: transceiver_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_NUMBER, default 256, giving carrier samples per symbol (power of two).
REQ-002 SHALL have parameter DATA_WIDTH, default 12, giving Hamming codeword bits, i.e. symbols per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, giving the received-byte buffer depth (power of two, >=2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65536, giving the tx_done watchdog limit.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 rx_dv  in  1  one-cycle strobe: rx_byte is valid.
REQ-008 rx_byte  in  8  byte from UART receiver.
REQ-009 sample_cnt  in  clog2(SAMPLE_NUMBER)  sine generator sample index.
REQ-010 dec_byte  in  8  Hamming decoder output.
REQ-011 tx_done  in  1  one-cycle strobe: UART transmitter finished a byte.
REQ-012 enc_wren  out  1  encoder load strobe.
REQ-013 enc_byte  out  8  byte presented to encoder.
REQ-014 gen_en  out  1  enable for sine generator, modulator and demodulator.
REQ-015 dec_rden  out  1  decoder read strobe.
REQ-016 tx_dv  out  1  transmitter start strobe.
REQ-017 tx_byte  out  8  byte presented to transmitter.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 overflow  out  1  one-cycle pulse: received byte dropped.
REQ-020 timeout_err  out  1  one-cycle pulse: watchdog expired (only with macro, else tied 0).

Function
REQ-021 FIFO SHALL push rx_byte when rx_dv=1 and not full, or when full and a pop occurs in the same cycle.
REQ-022 rx_dv=1 while full without a same-cycle pop SHALL drop the byte and pulse overflow next cycle; FIFO contents unchanged.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-024 FSM states: IDLE, LOAD, MOD, DEC, SEND, WAIT.
REQ-025 IDLE: if FIFO not empty, pop head into enc_byte and go to LOAD; otherwise stay in IDLE.
REQ-026 LOAD: enc_wren=1 for exactly one cycle; next state MOD.
REQ-027 MOD: gen_en=1 throughout; a symbol boundary is sample_cnt==SAMPLE_NUMBER-1 while gen_en=1.
REQ-028 MOD SHALL count boundaries in a symbol counter (cleared on entry); on the DATA_WIDTH-th boundary go to DEC.
REQ-029 DEC: dec_rden=1 for one cycle with gen_en=0; next state SEND.
REQ-030 SEND: tx_byte<=dec_byte registered and tx_dv=1 for one cycle; next state WAIT.
REQ-031 WAIT: on tx_done=1 go to IDLE; tx_done outside WAIT SHALL be ignored.
REQ-032 gen_en, enc_wren, dec_rden and tx_dv SHALL be registered and mutually exclusive.
REQ-033 Frame latency from first IDLE pop to tx_dv SHALL be 1 + MOD duration + 2 cycles.

Reset
REQ-034 rst=1 SHALL force IDLE, empty FIFO, clear the symbol and watchdog counters, and drive all outputs to 0.
REQ-035 rst asserted mid-frame SHALL abort the frame without issuing tx_dv; the buffered byte is lost.
REQ-036 rx_dv during a cycle with rst=1 SHALL be ignored.

Configuration
REQ-037 Macro TRANSCEIVER_CTRL_TIMEOUT_EN SHALL enable a WAIT-state watchdog.
REQ-038 When defined: the counter runs only in WAIT; after TIMEOUT_CYCLES cycles without tx_done, pulse timeout_err and go to IDLE.
REQ-039 When undefined: no counter; WAIT holds indefinitely; timeout_err is constant 0.

Verification
REQ-040 Single byte: rx_dv with 0xA5 -> enc_wren with enc_byte=0xA5; gen_en high for 12 boundaries; dec_rden; tx_dv with tx_byte=dec_byte; busy drops after tx_done.
REQ-041 Back-to-back: 5 rx_dv strobes with depth 4 during MOD -> overflow once on the 5th; the 4 buffered bytes are sent in order.
REQ-042 Simultaneous: FIFO full, rx_dv in the same cycle as the IDLE pop -> byte accepted, no overflow.
REQ-043 Reset in MOD after 5 boundaries -> all outputs 0 next cycle, no tx_dv, FIFO empty.
REQ-044 With macro, TIMEOUT_CYCLES=16, tx_done withheld -> timeout_err pulses 16 cycles after entering WAIT, then IDLE; without macro -> remains in WAIT.
REQ-045 Stray tx_done in IDLE/MOD -> no state change.
